// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the radix-2 Booth multiplier:
//   - controller state encoding (IDLE / RUN / DONE)
//   - default operand width
//   - Booth step counts for the signed-only and signed/unsigned builds
//   - Booth pair encodings of {Q[0], Q-1}
// Optional feature macro: MULT_UNSIGNED_EN (selects the 33-step count).
// -----------------------------------------------------------------------------
package mult_pkg;

  localparam int MULT_WIDTH     = 32;
  localparam int STEPS_SIGNED   = MULT_WIDTH;
  localparam int STEPS_UNSIGNED = MULT_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // {Q[0], Q-1} pairs that trigger an add or a subtract; 00/11 only shift.
  localparam logic [1:0] PAIR_ADD = 2'b01;
  localparam logic [1:0] PAIR_SUB = 2'b10;

  // Number of Booth iterations for a given operand width. Unsigned support
  // widens the operands by one bit, which costs one extra iteration.
  function automatic int booth_steps(input int width);
`ifdef MULT_UNSIGNED_EN
    return width + (STEPS_UNSIGNED - MULT_WIDTH);
`else
    return width + (STEPS_SIGNED - MULT_WIDTH);
`endif
  endfunction

endpackage

// File: rtl/booth_step.sv
// -----------------------------------------------------------------------------
// booth_step
// One combinational radix-2 Booth iteration: conditional add/subtract of M
// into the accumulator, then arithmetic shift right of {Acc, Q, Q-1}.
// Ports:
//   acc_i   [ACC_W-1:0]  current accumulator (one guard bit over the operand)
//   q_i     [OPW-1:0]    current multiplier / low product bits
//   q_m1_i               current Q-1 bit
//   m_i     [OPW-1:0]    multiplicand (two's complement)
//   acc_o, q_o, q_m1_o   next {Acc, Q, Q-1}
// -----------------------------------------------------------------------------
module booth_step
  import mult_pkg::*;
#(
  parameter int OPW   = 32,
  parameter int ACC_W = OPW + 1
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [OPW-1:0]   q_i,
  input  logic             q_m1_i,
  input  logic [OPW-1:0]   m_i,
  output logic [ACC_W-1:0] acc_o,
  output logic [OPW-1:0]   q_o,
  output logic             q_m1_o
);

  logic [ACC_W-1:0] m_ext_s;
  logic [ACC_W-1:0] sum_s;

  // The guard bit keeps Acc - M exact even when M is the most-negative value.
  assign m_ext_s = {{(ACC_W - OPW){m_i[OPW-1]}}, m_i};

  // Add, subtract or pass the accumulator depending on the Booth pair.
  always_comb begin
    sum_s = acc_i;
    case ({q_i[0], q_m1_i})
      PAIR_ADD: sum_s = acc_i + m_ext_s;
      PAIR_SUB: sum_s = acc_i - m_ext_s;
      default:  sum_s = acc_i;
    endcase
  end

  // Arithmetic shift right of {sum, Q, Q-1}, sign taken from the post-add sum.
  assign acc_o  = {sum_s[ACC_W-1], sum_s[ACC_W-1:1]};
  assign q_o    = {sum_s[0], q_i[OPW-1:1]};
  assign q_m1_o = q_i[0];

endmodule

// File: rtl/booth_mult.sv
// -----------------------------------------------------------------------------
// booth_mult
// Sequential WIDTH x WIDTH radix-2 Booth multiplier with start/done handshake.
// The 2*WIDTH product is held on hi/lo until the next completed operation.
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous active-low reset
//   start          request, sampled only in IDLE
//   multiplicand   operand A, captured when start is accepted
//   multiplier     operand B, captured when start is accepted
//   signed_op      1 = signed, 0 = unsigned (only with MULT_UNSIGNED_EN)
//   busy           high in RUN and DONE
//   done           one-cycle completion strobe
//   hi, lo         upper / lower product halves
// Optional feature macro: MULT_UNSIGNED_EN (adds signed_op, 33 Booth steps).
// -----------------------------------------------------------------------------
module booth_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
`ifdef MULT_UNSIGNED_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

`ifdef MULT_UNSIGNED_EN
  localparam int OPW = WIDTH + 1;
`else
  localparam int OPW = WIDTH;
`endif
  localparam int ACC_W = OPW + 1;
  localparam int STEPS = booth_steps(WIDTH);
  localparam int CNT_W = $clog2(STEPS + 1);

  state_t             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [OPW-1:0]     q_q;
  logic               q_m1_q;
  logic [OPW-1:0]     m_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic [ACC_W-1:0]   acc_d;
  logic [OPW-1:0]     q_d;
  logic               q_m1_d;
  logic [OPW-1:0]     m_ext_s;
  logic [OPW-1:0]     q_ext_s;
  logic [WIDTH-1:0]   hi_d;

  // Operand extension to the internal operand width.
  always_comb begin
`ifdef MULT_UNSIGNED_EN
    if (signed_op) begin
      m_ext_s = {multiplicand[WIDTH-1], multiplicand};
      q_ext_s = {multiplier[WIDTH-1], multiplier};
    end else begin
      m_ext_s = {1'b0, multiplicand};
      q_ext_s = {1'b0, multiplier};
    end
`else
    m_ext_s = multiplicand;
    q_ext_s = multiplier;
`endif
  end

  booth_step #(
    .OPW   (OPW),
    .ACC_W (ACC_W)
  ) u_step (
    .acc_i  (acc_q),
    .q_i    (q_q),
    .q_m1_i (q_m1_q),
    .m_i    (m_q),
    .acc_o  (acc_d),
    .q_o    (q_d),
    .q_m1_o (q_m1_d)
  );

  // Upper product half taken from the low 2*WIDTH bits of {Acc, Q}.
`ifdef MULT_UNSIGNED_EN
  assign hi_d = {acc_d[WIDTH-2:0], q_d[WIDTH]};
`else
  assign hi_d = acc_d[WIDTH-1:0];
`endif

  // Controller FSM, step counter and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      q_q     <= '0;
      q_m1_q  <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            m_q     <= m_ext_s;
            q_q     <= q_ext_s;
            acc_q   <= '0;
            q_m1_q  <= 1'b0;
            cnt_q   <= CNT_W'(STEPS);
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q  <= acc_d;
          q_q    <= q_d;
          q_m1_q <= q_m1_d;
          cnt_q  <= cnt_q - CNT_W'(1);
          // Last iteration: publish the product on the same edge.
          if (cnt_q == CNT_W'(1)) begin
            hi_q    <= hi_d;
            lo_q    <= q_d[WIDTH-1:0];
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_booth_mult.sv
module tb_booth_mult;

`ifdef MULT_UNSIGNED_EN
  localparam int STEPS = 33;
`else
  localparam int STEPS = 32;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] mcand = 32'd0;
  logic [31:0] mplier = 32'd0;
  logic        sg = 1'b1;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] p;
  } vec_t;

  vec_t tbl[$];

  booth_mult #(.WIDTH(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplier),
`ifdef MULT_UNSIGNED_EN
    .signed_op    (sg),
`endif
    .busy         (busy),
    .done         (done),
    .hi           (hi),
    .lo           (lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on sign- or zero-extended operands.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    return sa * sb;
  endfunction

  // One full operation: start, bounded wait for done, product/latency/strobe checks.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input string name, input logic [63:0] exp);
    int lat;
    @(negedge clock);
    start  = 1'b1;
    mcand  = a;
    mplier = b;
    sg     = s;
    @(posedge clock);
    #1;
    start  = 1'b0;
    mcand  = $urandom;
    mplier = $urandom;
    chk({name, " busy"}, {63'd0, busy}, 64'd1);
    lat = 0;
    while (!done && lat < STEPS + 10) begin
      @(posedge clock);
      #1;
      lat++;
    end
    chk({name, " latency"}, 64'(lat), 64'(STEPS));
    chk({name, " product"}, {hi, lo}, exp);
    @(posedge clock);
    #1;
    chk({name, " done width"}, {63'd0, done}, 64'd0);
    chk({name, " idle"}, {63'd0, busy}, 64'd0);
    chk({name, " held"}, {hi, lo}, exp);
  endtask

  initial begin
    int dones;
    int busies;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    logic [31:0] specials [5];

    specials = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    tbl.push_back('{32'd7,          32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB});
    tbl.push_back('{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000});
    tbl.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001});
    tbl.push_back('{32'h1234_5678, 32'd3,          1'b1, 64'h0000_0000_369D_0368});
    tbl.push_back('{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000});
`ifdef MULT_UNSIGNED_EN
    tbl.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001});
    tbl.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000});
`endif

    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset product", {hi, lo}, 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // Directed table.
    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].s, $sformatf("vec%0d", i), tbl[i].p);
    end

    // Randomized operations against the arithmetic reference.
    for (int n = 0; n < 24; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : 32'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : 32'($urandom);
`ifdef MULT_UNSIGNED_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b1;
`endif
      run_op(ra, rb, rs, $sformatf("rand%0d", n), ref_prod(ra, rb, rs));
    end

    // Start while busy: 5 x 6, second start at cycle 10 must be ignored.
    @(negedge clock);
    start = 1'b1; mcand = 32'd5; mplier = 32'd6; sg = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    dones = 0;
    for (int c = 1; c <= STEPS + 4; c++) begin
      @(negedge clock);
      if (c == 10) begin
        start = 1'b1; mcand = 32'd2; mplier = 32'd2;
      end else begin
        start = 1'b0;
      end
      @(posedge clock);
      #1;
      if (done) dones++;
    end
    chk("busy-start done count", 64'(dones), 64'd1);
    chk("busy-start product", {hi, lo}, 64'd30);
    chk("busy-start idle", {63'd0, busy}, 64'd0);
    run_op(32'd2, 32'd2, 1'b1, "after-busy", 64'd4);

    // Reset mid-operation at cycle 15.
    @(negedge clock);
    start = 1'b1; mcand = 32'h1234_5678; mplier = 32'd3; sg = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("midreset product", {hi, lo}, 64'd0);
    chk("midreset busy", {63'd0, busy}, 64'd0);
    chk("midreset done", {63'd0, done}, 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    dones = 0;
    busies = 0;
    repeat (STEPS + 3) begin
      @(posedge clock);
      #1;
      if (done) dones++;
      if (busy) busies++;
    end
    chk("midreset no done", 64'(dones), 64'd0);
    chk("midreset no busy", 64'(busies), 64'd0);
    chk("midreset held zero", {hi, lo}, 64'd0);
    run_op(32'h1234_5678, 32'd3, 1'b1, "post-reset", 64'h0000_0000_369D_0368);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
